// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles UART byte frames ('W' A3..A0 D3..D0 / 'R' A3..A0)
// into 32-bit read/write requests on a valid/ready interface, and flags bad
// headers, stop-bit errors, inter-byte timeouts and overruns.
module uart_cmd_parser #(
  parameter int unsigned P_TIMEOUT_CYC = 100000,
  parameter logic [7:0]  P_HDR_WR      = 8'h57,
  parameter logic [7:0]  P_HDR_RD      = 8'h52
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_rx_vld,
  input  logic [7:0]  i_rx_dat,
  input  logic        i_rx_stpbt_err,
  output logic        o_cmd_vld,
  input  logic        i_cmd_rdy,
  output logic        o_cmd_wr,
  output logic [31:0] o_cmd_addr,
  output logic [31:0] o_cmd_wdat,
  output logic        o_busy,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic [7:0]  o_err_cnt
);

  localparam int unsigned GAP_W = $clog2(P_TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WDAT = 2'd2,
    ST_CMD  = 2'd3
  } state_t;

  state_t           state;
  logic             wr;
  logic [31:0]      addr;
  logic [31:0]      wdat;
  logic [1:0]       byte_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             cmd_vld;
  logic             err;
  logic [1:0]       err_code;
  logic [7:0]       err_cnt;

  logic       is_hdr;
  logic       handshake;
  logic       idle_byte;
  logic       start;
  logic       gap_expired;
  logic       err_hit;
  logic [1:0] err_cause;

  // Byte classification and error cause for the current cycle.
  // A byte arriving in the handshake cycle is treated exactly like an idle byte.
  always_comb begin
    is_hdr      = (i_rx_dat == P_HDR_WR) || (i_rx_dat == P_HDR_RD);
    handshake   = (state == ST_CMD) && cmd_vld && i_cmd_rdy;
    idle_byte   = i_rx_vld && ((state == ST_IDLE) || handshake);
    start       = idle_byte && !i_rx_stpbt_err && is_hdr;
    gap_expired = !i_rx_vld && (gap_cnt == GAP_W'(P_TIMEOUT_CYC - 1));
    err_hit     = 1'b0;
    err_cause   = '0;
    if (idle_byte) begin
      if (i_rx_stpbt_err) begin
        err_hit   = 1'b1;
        err_cause = 2'd1;
      end else if (!is_hdr) begin
        err_hit   = 1'b1;
        err_cause = 2'd0;
      end
    end else if (state == ST_CMD) begin
      if (i_rx_vld) begin
        err_hit   = 1'b1;
        err_cause = 2'd3;
      end
    end else if ((state == ST_ADDR) || (state == ST_WDAT)) begin
      if (i_rx_vld && i_rx_stpbt_err) begin
        err_hit   = 1'b1;
        err_cause = 2'd1;
      end else if (gap_expired) begin
        err_hit   = 1'b1;
        err_cause = 2'd2;
      end
    end
  end

  // Frame FSM with registered command and error outputs.
  // The header check sits after the case so a new frame can start in the
  // same cycle a held command is accepted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      wr       <= 1'b0;
      addr     <= '0;
      wdat     <= '0;
      byte_idx <= '0;
      gap_cnt  <= '0;
      cmd_vld  <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
      err_cnt  <= '0;
    end else begin
      err <= err_hit;
      if (err_hit) begin
        err_code <= err_cause;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
      case (state)
        ST_IDLE: ;
        ST_ADDR: begin
          if (i_rx_vld) begin
            if (i_rx_stpbt_err) begin
              state <= ST_IDLE;
            end else begin
              addr     <= {addr[23:0], i_rx_dat};
              gap_cnt  <= '0;
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                if (wr) begin
                  state <= ST_WDAT;
                end else begin
                  state   <= ST_CMD;
                  cmd_vld <= 1'b1;
                end
              end
            end
          end else if (gap_expired) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_WDAT: begin
          if (i_rx_vld) begin
            if (i_rx_stpbt_err) begin
              state <= ST_IDLE;
            end else begin
              wdat     <= {wdat[23:0], i_rx_dat};
              gap_cnt  <= '0;
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                state   <= ST_CMD;
                cmd_vld <= 1'b1;
              end
            end
          end else if (gap_expired) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_CMD: begin
          if (handshake) begin
            cmd_vld <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (start) begin
        wr       <= (i_rx_dat == P_HDR_WR);
        addr     <= '0;
        wdat     <= '0;
        byte_idx <= '0;
        gap_cnt  <= '0;
        state    <= ST_ADDR;
      end
    end
  end

  assign o_cmd_vld  = cmd_vld;
  assign o_cmd_wr   = wr;
  assign o_cmd_addr = addr;
  assign o_cmd_wdat = wdat;
  assign o_busy     = (state != ST_IDLE);
  assign o_err      = err;
  assign o_err_code = err_code;
  assign o_err_cnt  = err_cnt;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed frames plus randomized byte streams; expected
// commands and errors are queued at stimulus time and consumed by a monitor.
module tb_uart_cmd_parser;

  localparam int unsigned P_TO = 50;
  localparam logic [7:0]  HW   = 8'h57;
  localparam logic [7:0]  HR   = 8'h52;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_vld = 1'b0;
  logic [7:0]  rx_dat = '0;
  logic        rx_stp = 1'b0;
  logic        cmd_rdy = 1'b0;
  logic        cmd_vld;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdat;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  err_cnt;

  uart_cmd_parser #(.P_TIMEOUT_CYC(P_TO), .P_HDR_WR(HW), .P_HDR_RD(HR)) dut (
    .clk(clk), .rstn(rstn),
    .i_rx_vld(rx_vld), .i_rx_dat(rx_dat), .i_rx_stpbt_err(rx_stp),
    .o_cmd_vld(cmd_vld), .i_cmd_rdy(cmd_rdy), .o_cmd_wr(cmd_wr),
    .o_cmd_addr(cmd_addr), .o_cmd_wdat(cmd_wdat), .o_busy(busy),
    .o_err(err), .o_err_code(err_code), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] wdat; } cmd_t;
  typedef struct packed { logic [1:0] code; logic [7:0] cnt; } err_t;

  cmd_t       cmd_q[$];
  err_t       err_q[$];
  logic [7:0] fr[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.wr = w; c.addr = a; c.wdat = d;
    cmd_q.push_back(c);
  endtask

  task automatic push_err(input logic [1:0] code);
    err_t e;
    if (exp_err_cnt < 255) exp_err_cnt++;
    e.code = code; e.cnt = 8'(exp_err_cnt);
    err_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe followed by idle_after idle cycles.
  task automatic drive_byte(input logic [7:0] b, input logic stp, input int unsigned idle_after);
    rx_vld = 1'b1; rx_dat = b; rx_stp = stp;
    tick();
    rx_vld = 1'b0; rx_stp = 1'b0;
    repeat (idle_after) tick();
  endtask

  task automatic send_rd(input logic [31:0] a);
    drive_byte(HR, 1'b0, 0);
    drive_byte(a[31:24], 1'b0, 0); drive_byte(a[23:16], 1'b0, 0);
    drive_byte(a[15:8], 1'b0, 0);  drive_byte(a[7:0], 1'b0, 0);
  endtask

  task automatic send_wr(input logic [31:0] a, input logic [31:0] d);
    drive_byte(HW, 1'b0, 0);
    drive_byte(a[31:24], 1'b0, 0); drive_byte(a[23:16], 1'b0, 0);
    drive_byte(a[15:8], 1'b0, 0);  drive_byte(a[7:0], 1'b0, 0);
    drive_byte(d[31:24], 1'b0, 0); drive_byte(d[23:16], 1'b0, 0);
    drive_byte(d[15:8], 1'b0, 0);  drive_byte(d[7:0], 1'b0, 0);
  endtask

  // Reference model: frame built as a byte list; command emitted when complete.
  task automatic model_byte(input logic [7:0] b, input logic stp);
    cmd_t c;
    if (fr.size() == 0) begin
      if (stp) push_err(2'd1);
      else if (b == HW || b == HR) fr.push_back(b);
      else push_err(2'd0);
    end else if (stp) begin
      push_err(2'd1);
      fr.delete();
    end else begin
      fr.push_back(b);
      if ((fr[0] == HW && fr.size() == 9) || (fr[0] == HR && fr.size() == 5)) begin
        c.wr = (fr[0] == HW);
        c.addr = 0;
        c.wdat = 0;
        for (int i = 1; i <= 4; i++) c.addr = c.addr * 256 + 32'(fr[i]);
        if (c.wr) for (int i = 5; i <= 8; i++) c.wdat = c.wdat * 256 + 32'(fr[i]);
        cmd_q.push_back(c);
        fr.delete();
      end
    end
  endtask

  // A partial frame dies if the strobe-to-strobe distance exceeds the timeout.
  task automatic model_gap(input int unsigned idle);
    if (fr.size() > 0 && idle + 1 > P_TO) begin
      push_err(2'd2);
      fr.delete();
    end
  endtask

  task automatic rand_byte(input logic [7:0] b, input logic stp, input int unsigned idle);
    model_byte(b, stp);
    model_gap(idle);
    drive_byte(b, stp, idle);
  endtask

  // Monitor: consumes expected errors and commands as the DUT presents them.
  always @(negedge clk) begin
    if (rstn) begin
      if (err) begin
        if (err_q.size() == 0) begin
          check("unexpected_err", 32'(err), 32'd0);
        end else begin
          err_t e;
          e = err_q.pop_front();
          check("err_code", 32'(err_code), 32'(e.code));
          check("err_cnt", 32'(err_cnt), 32'(e.cnt));
        end
      end
      if (cmd_vld) begin
        if (cmd_q.size() == 0) begin
          check("unexpected_cmd", 32'(cmd_vld), 32'd0);
        end else begin
          check("cmd_wr", 32'(cmd_wr), 32'(cmd_q[0].wr));
          check("cmd_addr", cmd_addr, cmd_q[0].addr);
          check("cmd_wdat", cmd_wdat, cmd_q[0].wdat);
          if (cmd_rdy) void'(cmd_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  fb [9];
    int unsigned n, r, stp_pos, gap_pos, idle;
    logic        w;

    // reset values
    repeat (3) tick();
    check("rst_vld", 32'(cmd_vld), 0);   check("rst_wr", 32'(cmd_wr), 0);
    check("rst_addr", cmd_addr, 0);      check("rst_wdat", cmd_wdat, 0);
    check("rst_busy", 32'(busy), 0);     check("rst_err", 32'(err), 0);
    check("rst_code", 32'(err_code), 0); check("rst_cnt", 32'(err_cnt), 0);
    rstn = 1'b1;
    tick();

    // 1: write held 20 cycles with rdy low
    push_cmd(1'b1, 32'h00001004, 32'hDEADBEEF);
    send_wr(32'h00001004, 32'hDEADBEEF);
    check("t1_latency", 32'(cmd_vld), 1);
    repeat (19) tick();
    cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    check("t1_vld_drop", 32'(cmd_vld), 0);

    // 2: read accepted immediately
    cmd_rdy = 1'b1;
    push_cmd(1'b0, 32'hA0000000, 32'h0);
    send_rd(32'hA0000000);
    check("t2_latency", 32'(cmd_vld), 1);
    tick();
    check("t2_vld_drop", 32'(cmd_vld), 0);
    check("t2_busy", 32'(busy), 0);

    // 3: bad header then a good read
    push_err(2'd0);
    drive_byte(8'h41, 1'b0, 0);
    check("t3_busy", 32'(busy), 0);
    push_cmd(1'b0, 32'hA0000000, 32'h0);
    send_rd(32'hA0000000);
    tick();

    // 4: timeout boundary, strobe-wins boundary, stop-bit errors
    push_err(2'd2);
    drive_byte(HW, 1'b0, 0);
    drive_byte(8'h12, 1'b0, 0);
    repeat (49) tick();
    check("t4_pre_err", 32'(err), 0);
    check("t4_pre_busy", 32'(busy), 1);
    tick();
    check("t4_to_err", 32'(err), 1);
    check("t4_to_busy", 32'(busy), 0);
    push_cmd(1'b0, 32'hA1B2C3D4, 32'h0);
    drive_byte(HR, 1'b0, P_TO - 1);
    drive_byte(8'hA1, 1'b0, 0); drive_byte(8'hB2, 1'b0, 0);
    drive_byte(8'hC3, 1'b0, 0); drive_byte(8'hD4, 1'b0, 2);
    push_err(2'd1);
    drive_byte(HR, 1'b0, 0);
    drive_byte(8'hA0, 1'b0, 0);
    drive_byte(8'h07, 1'b1, 0);
    check("t4_stp_busy", 32'(busy), 0);
    push_err(2'd1);
    drive_byte(HW, 1'b1, 0);
    check("t4_stphdr_busy", 32'(busy), 0);

    // 5: overrun, handshake with simultaneous header, reset mid-frame
    cmd_rdy = 1'b0;
    push_cmd(1'b0, 32'h11223344, 32'h0);
    send_rd(32'h11223344);
    check("t5_latency", 32'(cmd_vld), 1);
    push_err(2'd3);
    drive_byte(HW, 1'b0, 1);
    push_err(2'd3);
    drive_byte(8'h99, 1'b0, 1);
    check("t5_ovr_busy", 32'(busy), 1);
    cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    check("t5_vld_drop", 32'(cmd_vld), 0);
    check("t5_busy", 32'(busy), 0);
    push_cmd(1'b0, 32'h01020304, 32'h0);
    send_rd(32'h01020304);
    tick(); tick();
    push_cmd(1'b0, 32'h0A0B0C0D, 32'h0);
    cmd_rdy = 1'b1;
    drive_byte(HR, 1'b0, 0);
    check("t5_hs_vld", 32'(cmd_vld), 0);
    check("t5_hs_busy", 32'(busy), 1);
    drive_byte(8'h0A, 1'b0, 0); drive_byte(8'h0B, 1'b0, 0);
    drive_byte(8'h0C, 1'b0, 0); drive_byte(8'h0D, 1'b0, 0);
    tick();
    drive_byte(HW, 1'b0, 0); drive_byte(8'h01, 1'b0, 0); drive_byte(8'h02, 1'b0, 0);
    rstn = 1'b0;
    tick(); tick();
    check("t5_rst_vld", 32'(cmd_vld), 0); check("t5_rst_wr", 32'(cmd_wr), 0);
    check("t5_rst_addr", cmd_addr, 0);    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_cnt", 32'(err_cnt), 0); check("t5_rst_err", 32'(err), 0);
    exp_err_cnt = 0;
    rstn = 1'b1;
    tick();
    push_cmd(1'b1, 32'hCAFE0001, 32'h12345678);
    send_wr(32'hCAFE0001, 32'h12345678);
    tick();

    // randomized streams through the reference model, rdy held high
    for (int f = 0; f < 40; f++) begin
      w = 1'($urandom % 2);
      r = $urandom % 10;
      n = w ? 9 : 5;
      fb[0] = w ? HW : HR;
      for (int j = 1; j < 9; j++) fb[j] = 8'($urandom);
      if (r == 0) fb[0] = fb[0] ^ 8'h01;
      stp_pos = (r == 1) ? $urandom % n : 99;
      gap_pos = (r == 2) ? $urandom % (n - 1) : 99;
      for (int unsigned j = 0; j < n; j++) begin
        idle = (j == gap_pos) ? (P_TO - 1) + $urandom % 8 : $urandom % 4;
        rand_byte(fb[j], (j == stp_pos), idle);
      end
    end
    model_gap(P_TO + 10);
    repeat (P_TO + 10) tick();

    // 6: error counter saturation
    for (int k = 0; k < 300; k++) begin
      push_err(2'd0);
      drive_byte(8'h41, 1'b0, 0);
    end
    tick();
    check("t6_cnt_sat", 32'(err_cnt), 32'hFF);

    repeat (5) tick();
    check("cmd_q_drained", 32'(cmd_q.size()), 0);
    check("err_q_drained", 32'(err_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
